settings_frame_receiver: RTL
============================

# settings_frame_receiver

Assembles the 5-byte settings command frame (command byte, then 32-bit value little-endian) from the UART receive byte stream. Writes it into the settings buffer RAM at addresses 0..4, then hands off to `settings_data_handler` with a one-cycle `start` pulse and waits for its `done`/`error`. Reports per-frame status upward. Sits directly upstream of `settings_data_handler` and owns the write port of its 5-byte buffer RAM.

## Interface
- `TIMEOUT_CYCLES`, default 1_000_000: max idle cycles between bytes in a partial frame, and max wait for handler completion.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `rx_valid`  in  1  one-cycle strobe: `rx_data` holds a received byte.
- `rx_data`  in  8  received byte.
- `buf_wr_en`  out  1  buffer RAM write strobe.
- `buf_wr_addr`  out  3  buffer RAM write address, 0..4.
- `buf_wr_data`  out  8  buffer RAM write data.
- `handler_start`  out  1  start pulse to `settings_data_handler`.
- `handler_done`  in  1  handler completed OK.
- `handler_error`  in  1  handler error; sticky until reset.
- `frame_ok`  out  1  one-cycle pulse: frame applied.
- `frame_err`  out  1  one-cycle pulse: frame failed.
- `err_code`  out  2  valid with `frame_err`, held until the next `frame_err`:
  - 1 = inter-byte or handler timeout
  - 2 = handler error
  - 3 = overrun
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, COLLECT, DISPATCH, WAIT.
- **IDLE**
  - On `rx_valid`: write byte to addr 0, set byte count to 1, clear timeout counter, go to COLLECT.
- **COLLECT**
  - On `rx_valid`: write byte to addr = count, count+1, clear timeout counter.
  - After the 5th byte: go to DISPATCH.
  - Otherwise the timeout counter increments each cycle. At `TIMEOUT_CYCLES`: `frame_err`, code 1, go to IDLE. Partial bytes stay in RAM and are overwritten by the next frame.
- **DISPATCH** (one cycle)
  - If `handler_error` is already high: do not start the handler; `frame_err`, code 2, go to IDLE.
  - Else: assert `handler_start`, clear timeout counter, go to WAIT.
- **WAIT**
  - Ignores `handler_done`/`handler_error` in its first cycle (the cycle `handler_start` is high).
  - Afterwards, on the first cycle either is high, resolve by priority:
    - `handler_error` → `frame_err`, code 2.
    - Else overrun latch set → `frame_err`, code 3.
    - Else `handler_done` → `frame_ok`.
  - Go to IDLE after resolving.
  - Timeout counter at `TIMEOUT_CYCLES` → `frame_err`, code 1, IDLE.
- **Overrun:** `rx_valid` in DISPATCH or WAIT drops the byte (no RAM write) and sets the overrun latch. The latch clears on entry to IDLE.
- Byte count is 3 bits, never exceeds 5, never wraps. Timeout counter is 32 bits and saturates.

## Timing
- All outputs are registered.
- **Reset:** every output is 0, `buf_wr_addr`=0, `err_code`=0, state IDLE, count 0, latches cleared. Asserting `rst` mid-frame or mid-WAIT aborts immediately, with no status pulse.
- **Byte write:** `rx_valid` sampled at edge E → `buf_wr_en`/`buf_wr_addr`/`buf_wr_data` valid for exactly the cycle after E. Back-to-back `rx_valid` on consecutive cycles must be accepted with no loss.
- **Start:** 5th byte sampled at edge E → `handler_start` high for exactly one cycle, beginning after edge E+1. The last RAM write therefore completes one cycle before the handler samples `start`.
- **Completion:** `frame_ok`/`frame_err` go high the cycle after the edge that samples `handler_done`/`handler_error`, for exactly one cycle. `busy` falls in the same cycle.
- `rx_valid` arriving in the same cycle that `frame_ok`/`frame_err` is high (state already IDLE) is accepted as byte 0 of the next frame.
- Timeout fires exactly `TIMEOUT_CYCLES` cycles after the last accepted byte (or after `handler_start`).

## Test plan
- **Valid frame:** bytes 01 0A 00 00 00, 2 idle cycles apart → RAM[0..4]=01,0A,00,00,00; one `handler_start` 2 cycles after the last byte. Then handler `done` → one `frame_ok`; with the real handler, `settings_max_row`=10.
- **Back-to-back:** frame 05 0C 00 00 00 on consecutive cycles → 5 consecutive write cycles at addrs 0..4; `frame_ok`; `settings_countdown_time`=12.
- **Timeout:** `TIMEOUT_CYCLES`=100; send 3 bytes then go silent → `frame_err`, code 1, exactly 100 cycles after byte 3; no `handler_start`. A following valid frame writes from addr 0 and succeeds.
- **Handler rejection:** frame 01 21 00 00 00 (row=33) → `frame_err`, code 2. A second valid frame without reset → no `handler_start`; `frame_err`, code 2 in the cycle after DISPATCH.
- **Overrun:** extra byte 0x55 sent while in WAIT → no RAM write; `frame_err`, code 3 on `done`. Next frame succeeds with `frame_ok`.
- **Reset mid-frame:** `rst` pulsed after 2 bytes → all outputs 0, no pulse. The next 5 bytes form a full frame starting at addr 0.

Source files
------------

// File: rtl/settings_frame_receiver.sv
// Collects the 5-byte settings frame (command + 32-bit LE value) into the handler buffer RAM,
// pulses handler_start, then reports per-frame ok/error status from the handler outcome.
module settings_frame_receiver #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       buf_wr_en,
  output logic [2:0] buf_wr_addr,
  output logic [7:0] buf_wr_data,
  output logic       handler_start,
  input  logic       handler_done,
  input  logic       handler_error,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, COLLECT, DISPATCH, WAIT} state_t;

  localparam logic [31:0] TMO_LAST    = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]  LAST_BYTE   = 3'd4;
  localparam logic [1:0]  ERR_TIMEOUT = 2'd1;
  localparam logic [1:0]  ERR_HANDLER = 2'd2;
  localparam logic [1:0]  ERR_OVERRUN = 2'd3;

  state_t      state, state_nxt;
  logic [2:0]  count;
  logic [31:0] tmo_cnt;
  logic        overrun;
  logic        tmo_hit;
  logic        resolve;

  logic        wr_en_d;
  logic [2:0]  wr_addr_d;
  logic [7:0]  wr_data_d;
  logic        start_d;
  logic        ok_d;
  logic        err_d;
  logic [1:0]  code_d;

  // Firing one count early makes the status land exactly TIMEOUT_CYCLES after the reference edge.
  assign tmo_hit = (tmo_cnt >= TMO_LAST);
  // handler_start is still high in the first WAIT cycle, which masks stale done/error there.
  assign resolve = (state == WAIT) && !handler_start && (handler_done || handler_error);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (rx_valid) state_nxt = COLLECT;
      COLLECT: begin
        if (rx_valid) begin
          if (count == LAST_BYTE) state_nxt = DISPATCH;
        end else if (tmo_hit) begin
          state_nxt = IDLE;
        end
      end
      DISPATCH: state_nxt = handler_error ? IDLE : WAIT;
      WAIT:     if (resolve || tmo_hit) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = buf_wr_addr;
    wr_data_d = buf_wr_data;
    start_d   = 1'b0;
    ok_d      = 1'b0;
    err_d     = 1'b0;
    code_d    = err_code;
    case (state)
      IDLE: begin
        if (rx_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = 3'd0;
          wr_data_d = rx_data;
        end
      end
      COLLECT: begin
        if (rx_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = count;
          wr_data_d = rx_data;
        end else if (tmo_hit) begin
          err_d  = 1'b1;
          code_d = ERR_TIMEOUT;
        end
      end
      DISPATCH: begin
        if (handler_error) begin
          err_d  = 1'b1;
          code_d = ERR_HANDLER;
        end else begin
          start_d = 1'b1;
        end
      end
      WAIT: begin
        if (resolve) begin
          if (handler_error) begin
            err_d  = 1'b1;
            code_d = ERR_HANDLER;
          end else if (overrun) begin
            err_d  = 1'b1;
            code_d = ERR_OVERRUN;
          end else begin
            ok_d = 1'b1;
          end
        end else if (tmo_hit) begin
          err_d  = 1'b1;
          code_d = ERR_TIMEOUT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_wr_en     <= 1'b0;
      buf_wr_addr   <= 3'd0;
      buf_wr_data   <= 8'd0;
      handler_start <= 1'b0;
      frame_ok      <= 1'b0;
      frame_err     <= 1'b0;
      err_code      <= 2'd0;
      busy          <= 1'b0;
    end else begin
      buf_wr_en     <= wr_en_d;
      buf_wr_addr   <= wr_addr_d;
      buf_wr_data   <= wr_data_d;
      handler_start <= start_d;
      frame_ok      <= ok_d;
      frame_err     <= err_d;
      err_code      <= code_d;
      busy          <= (state_nxt != IDLE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= 3'd0;
      tmo_cnt <= 32'd0;
      overrun <= 1'b0;
    end else begin
      case (state)
        IDLE:    count <= rx_valid ? 3'd1 : 3'd0;
        COLLECT: if (rx_valid && count <= LAST_BYTE) count <= count + 3'd1;
        default: ;
      endcase

      if (state == IDLE || state == DISPATCH || (state == COLLECT && rx_valid))
        tmo_cnt <= 32'd0;
      else if (tmo_cnt != '1)
        tmo_cnt <= tmo_cnt + 32'd1;

      // Bytes arriving while the handler owns the buffer are dropped and poison the frame.
      if (state_nxt == IDLE)
        overrun <= 1'b0;
      else if (rx_valid && (state == DISPATCH || state == WAIT))
        overrun <= 1'b1;
    end
  end

endmodule
